// File: rtl/pool_relu_stream.sv
// Per-lane max/average pooling over POOL_K beats, then an optional ReLU, on a valid/ready output register.
// Build option POOL_RELU_LEAKY_EN: a negative ReLU input becomes value >>> 3 instead of 0.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

module pool_relu_stream #(
  parameter int DATA_WID = `CNN_XLEN,
  parameter int LANES    = 4,
  parameter int POOL_K   = 4,
  parameter int LOG2_K   = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      cfg_avg_i,
  input  logic                      cfg_relu_en_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES*DATA_WID-1:0] in_data_i,
  input  logic                      in_last_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LANES*DATA_WID-1:0] out_data_o,
  output logic                      out_partial_o
);

  localparam int AW = DATA_WID + LOG2_K;
  localparam logic [LOG2_K:0] CNT_LAST = (LOG2_K + 1)'(POOL_K - 1);

  logic [LOG2_K:0]           cnt_q;
  logic                      avg_q;
  logic                      relu_q;
  logic signed [AW-1:0]      acc_q [LANES];
  logic                      out_valid_q;
  logic [LANES*DATA_WID-1:0] out_data_q;
  logic                      out_partial_q;

  logic signed [AW-1:0]       x_ext    [LANES];
  logic signed [AW-1:0]       acc_d    [LANES];
  logic signed [DATA_WID-1:0] pool_res [LANES];
  logic signed [DATA_WID-1:0] act_res  [LANES];
  logic [LANES*DATA_WID-1:0]  out_data_d;
  logic                       accept;
  logic                       first_beat;
  logic                       close_win;
  logic                       mode_avg;
  logic                       mode_relu;

  // The first beat of a window uses the live cfg inputs; later beats use the latched copy.
  always_comb begin
    in_ready_o = !(out_valid_q && !out_ready_i);
    accept     = in_valid_i && in_ready_o;
    first_beat = (cnt_q == '0);
    mode_avg   = first_beat ? cfg_avg_i : avg_q;
    mode_relu  = first_beat ? cfg_relu_en_i : relu_q;
    close_win  = accept && ((cnt_q == CNT_LAST) || in_last_i);
  end

  always_comb begin
    out_data_d = '0;
    for (int i = 0; i < LANES; i++) begin
      x_ext[i] = {{LOG2_K{in_data_i[i*DATA_WID + DATA_WID - 1]}},
                  in_data_i[i*DATA_WID +: DATA_WID]};
      if (first_beat) begin
        acc_d[i] = x_ext[i];
      end else if (mode_avg) begin
        acc_d[i] = acc_q[i] + x_ext[i];
      end else begin
        acc_d[i] = (x_ext[i] > acc_q[i]) ? x_ext[i] : acc_q[i];
      end
      pool_res[i] = mode_avg ? DATA_WID'(acc_d[i] >>> LOG2_K) : DATA_WID'(acc_d[i]);
      if (mode_relu && pool_res[i][DATA_WID-1]) begin
`ifdef POOL_RELU_LEAKY_EN
        act_res[i] = pool_res[i] >>> 3;
`else
        act_res[i] = '0;
`endif
      end else begin
        act_res[i] = pool_res[i];
      end
      out_data_d[i*DATA_WID +: DATA_WID] = act_res[i];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q         <= '0;
      avg_q         <= 1'b0;
      relu_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_partial_q <= 1'b0;
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end else begin
      if (accept) begin
        cnt_q <= close_win ? '0 : cnt_q + 1'b1;
        if (first_beat) begin
          avg_q  <= cfg_avg_i;
          relu_q <= cfg_relu_en_i;
        end
        for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
      end
      // A closing window reloads the output even in the cycle the old result drains.
      if (close_win) begin
        out_valid_q   <= 1'b1;
        out_data_q    <= out_data_d;
        out_partial_q <= (cnt_q != CNT_LAST);
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_partial_o = out_partial_q;

endmodule

// File: tb/tb_pool_relu_stream.sv
// Bench for pool_relu_stream: window-level arithmetic model, per-cycle compare, directed scenarios.
module tb_pool_relu_stream;
  localparam int DW = 16;
  localparam int LN = 4;
  localparam int K  = 4;
  localparam int LK = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_avg = 1'b0;
  logic cfg_relu = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [LN*DW-1:0] in_data = '0;
  logic in_ready;
  logic out_valid;
  logic out_partial;
  logic [LN*DW-1:0] out_data;

  pool_relu_stream #(.DATA_WID(DW), .LANES(LN), .POOL_K(K), .LOG2_K(LK)) dut (
    .clk_i(clk), .reset_i(reset), .cfg_avg_i(cfg_avg), .cfg_relu_en_i(cfg_relu),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_partial_o(out_partial)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [LN*DW-1:0] d;
    bit p;
  } res_t;
  res_t exp_q[$];
  int   log_l0[$];
  int   log_l2[$];
  int   log_p[$];

  int wcnt = 0;
  int wsum[LN];
  int wmax[LN];
  bit wavg;
  bit wrelu;

  function automatic int lane_val(input int v, input int i);
    case (i)
      0: return v;
      1: return -v;
      2: return v + 100;
      default: return 3 * v;
    endcase
  endfunction

  function automatic logic [LN*DW-1:0] mk(input int v);
    logic [LN*DW-1:0] d;
    for (int i = 0; i < LN; i++) d[i*DW +: DW] = DW'(lane_val(v, i));
    return d;
  endfunction

  function automatic int activate(input int r, input bit relu);
    if (relu && r < 0) begin
`ifdef POOL_RELU_LEAKY_EN
      return r >>> 3;
`else
      return 0;
`endif
    end
    return r;
  endfunction

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [LN*DW-1:0] got, input logic [LN*DW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Window model: accumulate plain integers, emit one expected result per closed window.
  task automatic model_beat();
    int x;
    int r;
    res_t e;
    for (int i = 0; i < LN; i++) begin
      x = int'($signed(in_data[i*DW +: DW]));
      if (wcnt == 0) begin
        wsum[i] = x;
        wmax[i] = x;
      end else begin
        wsum[i] += x;
        if (x > wmax[i]) wmax[i] = x;
      end
    end
    if (wcnt == 0) begin
      wavg  = cfg_avg;
      wrelu = cfg_relu;
    end
    wcnt++;
    if (wcnt == K || in_last) begin
      for (int i = 0; i < LN; i++) begin
        r = wavg ? (wsum[i] >>> LK) : wmax[i];
        r = activate(r, wrelu);
        e.d[i*DW +: DW] = DW'(r);
      end
      e.p = (wcnt < K);
      exp_q.push_back(e);
      wcnt = 0;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      wcnt = 0;
      check("valid_in_reset", int'(out_valid), 0);
    end else begin
      check("out_valid", int'(out_valid), int'(exp_q.size() > 0));
      check("in_ready", int'(in_ready), int'(!(exp_q.size() > 0 && !out_ready)));
      if (out_valid && exp_q.size() > 0) begin
        check_vec("out_data", out_data, exp_q[0].d);
        check("out_partial", int'(out_partial), int'(exp_q[0].p));
        if (out_ready) begin
          log_l0.push_back(int'($signed(exp_q[0].d[DW-1:0])));
          log_l2.push_back(int'($signed(exp_q[0].d[2*DW +: DW])));
          log_p.push_back(int'(exp_q[0].p));
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) model_beat();
    end
  end

  task automatic send(input int v, input bit last);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = mk(v);
    in_last  = last;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: beat %0d never accepted", v);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    // Max with ReLU; result must appear one cycle after the closing beat.
    cfg_avg = 1'b0; cfg_relu = 1'b1;
    send(3, 0); send(-7, 0); send(9, 0); send(2, 0);
    check("t1_latency", int'(out_valid), 1);
    idle(2);

    // Average, first without then with ReLU.
    cfg_avg = 1'b1; cfg_relu = 1'b0;
    send(-4, 0); send(-4, 0); send(-4, 0); send(-8, 0);
    cfg_relu = 1'b1;
    send(-4, 0); send(-4, 0); send(-4, 0); send(-8, 0);
    idle(2);

    // Backpressure while the next window streams in.
    cfg_avg = 1'b0; cfg_relu = 1'b0; out_ready = 1'b0;
    fork
      begin
        send(1, 0); send(5, 0); send(2, 0); send(8, 0);
        send(-3, 0); send(-1, 0); send(-9, 0); send(-2, 0);
      end
      begin
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(3);

    // Early close on the second beat, then a clean full window.
    send(5, 0); send(11, 1);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    idle(3);

    // Reset mid-window discards it; the next four beats form a fresh window.
    send(7, 0); send(-6, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check("t5_reset_valid", int'(out_valid), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(1);
    send(2, 0); send(3, 0); send(4, 0); send(5, 0);
    idle(3);

    // Mode change mid-window applies only to the following window.
    cfg_avg = 1'b0;
    send(1, 0); send(8, 0);
    cfg_avg = 1'b1;
    send(2, 0); send(3, 0);
    send(4, 0); send(4, 0); send(4, 0); send(4, 0);
    idle(5);

    check("result_count", log_l0.size(), 10);
    if (log_l0.size() >= 10) begin
      check("r0_lane0", log_l0[0], 9);
      check("r0_lane2", log_l2[0], 109);
      check("r0_partial", log_p[0], 0);
      check("r1_lane0", log_l0[1], -5);
      check("r1_lane2", log_l2[1], 95);
`ifdef POOL_RELU_LEAKY_EN
      check("r2_lane0", log_l0[2], -1);
`else
      check("r2_lane0", log_l0[2], 0);
`endif
      check("r3_lane0", log_l0[3], 8);
      check("r4_lane0", log_l0[4], -1);
      check("r5_lane0", log_l0[5], 11);
      check("r5_partial", log_p[5], 1);
      check("r6_lane0", log_l0[6], 4);
      check("r6_partial", log_p[6], 0);
      check("r7_lane0", log_l0[7], 5);
      check("r8_lane0", log_l0[8], 8);
      check("r9_lane0", log_l0[9], 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
